// File: rtl/sipo_collect_if.sv
// Handshake and data bundle between a serial-adder producer and the SIPO collector.
// The master side drives the serial stream and ack; the slave side presents the word.
interface sipo_collect_if #(
  parameter int WIDTH = 4
);
  logic             clear;
  logic             shift;
  logic             d_in;
  logic             c_in;
  logic             ack;
  logic [WIDTH-1:0] d_out;
  logic             c_out;
  logic             valid;
  logic             busy;
  logic             overrun;

  modport master (
    output clear, shift, d_in, c_in, ack,
    input  d_out, c_out, valid, busy, overrun
  );

  modport slave (
    input  clear, shift, d_in, c_in, ack,
    output d_out, c_out, valid, busy, overrun
  );
endinterface

// File: rtl/sipo_collect.sv
// Serial-in parallel-out collector: gathers WIDTH LSB-first bits plus the final
// carry into a word and holds it until the consumer acknowledges it.
module sipo_collect #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          reset,
  sipo_collect_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FULL    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_shadow;
  logic [WIDTH-1:0] r_d_out;
  logic             r_c_out;
  logic             r_overrun;

  logic             w_accept;
  logic             w_last;
  logic             w_drop;
  logic [WIDTH-1:0] w_shift_word;

  // New bits enter at the MSB so the first bit ends up in bit 0 after WIDTH shifts.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_shift_word = bus.d_in;
    end else begin : g_wn
      assign w_shift_word = {bus.d_in, r_shadow[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = w_accept && (r_count == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.shift) begin
          w_accept     = 1'b1;
          w_state_next = (r_count == LAST_IDX) ? FULL : COLLECT;
        end
      end
      COLLECT: begin
        if (bus.shift) begin
          w_accept     = 1'b1;
          w_state_next = (r_count == LAST_IDX) ? FULL : COLLECT;
        end
      end
      FULL: begin
        if (bus.ack) begin
          if (bus.shift) begin
            // Handover: this bit is bit 0 of the next word, nothing is lost.
            w_accept     = 1'b1;
            w_state_next = (r_count == LAST_IDX) ? FULL : COLLECT;
          end else begin
            w_state_next = IDLE;
          end
        end else if (bus.shift) begin
          w_drop = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
    if (bus.clear) begin
      w_state_next = IDLE;
      w_accept     = 1'b0;
      w_drop       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count   <= '0;
      r_shadow  <= '0;
      r_d_out   <= '0;
      r_c_out   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (bus.clear) begin
      // Abort keeps the last completed word visible on d_out/c_out.
      r_count   <= '0;
      r_shadow  <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shadow <= w_shift_word;
        if (w_last) begin
          r_count <= '0;
          r_d_out <= w_shift_word;
          r_c_out <= bus.c_in;
        end else begin
          r_count <= r_count + CW'(1);
        end
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign bus.d_out   = r_d_out;
  assign bus.c_out   = r_c_out;
  assign bus.valid   = (r_state == FULL);
  assign bus.busy    = (r_state == COLLECT);
  assign bus.overrun = r_overrun;

endmodule
